// File: rtl/hazard_sequencer_if.sv
// Hazard-unit bundle: stage register addresses, write enables and PC-source
// flags coming in from the pipeline, plus the forward/stall/flush controls going back.
interface hazard_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       RA1D, RA2D;
    logic [3:0]       RA1E, RA2E;
    logic [3:0]       WA3E, WA3M, WA3W;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic             BranchTakenE;
    logic             StartMulE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM;
    logic             MulBusyE;
    logic             MulDoneE;
    logic [CNT_W-1:0] StallCycles;

    // Pipeline side: drives the stage information, receives the controls.
    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, StartMulE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MulBusyE, MulDoneE, StallCycles
    );

    // Hazard unit side.
    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, StartMulE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MulBusyE, MulDoneE, StallCycles
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W core:
// operand forwarding, load-use and multi-cycle-op stalls, branch flushes,
// and a saturating count of Decode stall cycles.
module hazard_sequencer #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned CNT_W      = 16
) (
    input logic               clk,
    input logic               reset,
    hazard_sequencer_if.slave hz
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bool_multi  = (MUL_CYCLES > 1);
    localparam logic [3:0] CNT_INIT = bool_multi ? 4'(MUL_CYCLES - 2) : 4'd0;

    state_t           state;
    logic [3:0]       cnt;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    logic             mul_start;
    logic             mul_stall;
    logic             mul_done;
    logic             ldr_stall;
    logic             pc_wr_pending;
    logic             stall_d;

    // Operand forwarding: Memory stage beats Writeback; r15 is never forwarded.
    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && (hz.RA1E == hz.WA3M) && (hz.RA1E != 4'd15))
            hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && (hz.RA1E == hz.WA3W) && (hz.RA1E != 4'd15))
            hz.ForwardAE = 2'b01;
        if (hz.RegWriteM && (hz.RA2E == hz.WA3M) && (hz.RA2E != 4'd15))
            hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && (hz.RA2E == hz.WA3W) && (hz.RA2E != 4'd15))
            hz.ForwardBE = 2'b01;
    end

    // Stall/flush decode. A taken branch cancels a multiply start in the same cycle.
    always_comb begin
        mul_start     = (state == IDLE) && hz.StartMulE && !hz.BranchTakenE;
        mul_stall     = (mul_start && bool_multi) ||
                        ((state == BUSY) && (cnt != 4'd0));
        mul_done      = (mul_start && !bool_multi) ||
                        ((state == BUSY) && (cnt == 4'd0));
        ldr_stall     = hz.MemtoRegE && hz.RegWriteE &&
                        ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));
        pc_wr_pending = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
        stall_d       = ldr_stall || mul_stall;

        hz.StallF      = ldr_stall || pc_wr_pending || mul_stall;
        hz.StallD      = stall_d;
        hz.StallE      = mul_stall;
        hz.FlushD      = (pc_wr_pending || hz.PCSrcW || hz.BranchTakenE) && !stall_d;
        hz.FlushE      = (ldr_stall || hz.BranchTakenE) && !mul_stall;
        hz.FlushM      = mul_stall;
        hz.MulDoneE    = mul_done;
        hz.MulBusyE    = mul_busy;
        hz.StallCycles = stall_cycles;
    end

    // Multi-cycle op sequencer plus saturating Decode-stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            mul_busy     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start && bool_multi) begin
                        state    <= BUSY;
                        cnt      <= CNT_INIT;
                        mul_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= IDLE;
                        mul_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    mul_busy <= 1'b0;
                end
            endcase

            if (stall_d && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: forwarding priority, load-use stall,
// multi-cycle op sequencing, branch interaction, reset mid-op, counter saturation.
module tb_hazard_sequencer;

    localparam int unsigned MUL_CYCLES = 3;
    localparam int unsigned CNT_W      = 8;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

    hazard_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Quiet inputs: registers chosen so nothing matches anything.
    task automatic quiet();
        hz.RA1D = 4'd1;  hz.RA2D = 4'd2;
        hz.RA1E = 4'd1;  hz.RA2E = 4'd2;
        hz.WA3E = 4'd9;  hz.WA3M = 4'd10; hz.WA3W = 4'd11;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0;
        hz.PCSrcD = 1'b0; hz.PCSrcE = 1'b0; hz.PCSrcM = 1'b0; hz.PCSrcW = 1'b0;
        hz.BranchTakenE = 1'b0;
        hz.StartMulE = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        quiet();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_busy",   16'(hz.MulBusyE), 16'd0);
        check("rst_cnt",    16'(hz.StallCycles), 16'd0);
        check("rst_stallf", 16'(hz.StallF), 16'd0);
        check("rst_flushd", 16'(hz.FlushD), 16'd0);

        // Forwarding priority
        hz.RegWriteM = 1'b1; hz.WA3M = 4'd3;
        hz.RegWriteW = 1'b1; hz.WA3W = 4'd3;
        hz.RA1E = 4'd3; hz.RA2E = 4'd3;
        #1;
        check("fwdA_m",   16'(hz.ForwardAE), 16'd2);
        check("fwdB_m",   16'(hz.ForwardBE), 16'd2);
        hz.RA1E = 4'd15;
        #1;
        check("fwdA_r15", 16'(hz.ForwardAE), 16'd0);
        hz.RA1E = 4'd3; hz.RegWriteM = 1'b0;
        #1;
        check("fwdA_w",   16'(hz.ForwardAE), 16'd1);
        check("fwdB_w",   16'(hz.ForwardBE), 16'd1);
        hz.RegWriteW = 1'b0;
        #1;
        check("fwdA_rf",  16'(hz.ForwardAE), 16'd0);
        quiet();

        // Load-use stall for one cycle
        step();
        hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WA3E = 4'd5; hz.RA2D = 4'd5;
        #1;
        check("ld_stallf", 16'(hz.StallF), 16'd1);
        check("ld_stalld", 16'(hz.StallD), 16'd1);
        check("ld_flushe", 16'(hz.FlushE), 16'd1);
        check("ld_flushd", 16'(hz.FlushD), 16'd0);
        check("ld_stalle", 16'(hz.StallE), 16'd0);
        step();
        quiet();
        #1;
        check("ld_cnt",    16'(hz.StallCycles), 16'd1);

        // Multi-cycle op, 3 cycles in Execute
        hz.StartMulE = 1'b1;
        #1;
        check("mul1_stalle", 16'(hz.StallE), 16'd1);
        check("mul1_flushm", 16'(hz.FlushM), 16'd1);
        check("mul1_busy",   16'(hz.MulBusyE), 16'd0);
        check("mul1_done",   16'(hz.MulDoneE), 16'd0);
        step();
        check("mul2_stalle", 16'(hz.StallE), 16'd1);
        check("mul2_flushm", 16'(hz.FlushM), 16'd1);
        check("mul2_busy",   16'(hz.MulBusyE), 16'd1);
        check("mul2_done",   16'(hz.MulDoneE), 16'd0);
        step();
        check("mul3_stalle", 16'(hz.StallE), 16'd0);
        check("mul3_stalld", 16'(hz.StallD), 16'd0);
        check("mul3_stallf", 16'(hz.StallF), 16'd0);
        check("mul3_busy",   16'(hz.MulBusyE), 16'd1);
        check("mul3_done",   16'(hz.MulDoneE), 16'd1);
        step();
        hz.StartMulE = 1'b0;
        #1;
        check("mul4_busy",   16'(hz.MulBusyE), 16'd0);
        check("mul4_done",   16'(hz.MulDoneE), 16'd0);
        check("mul4_cnt",    16'(hz.StallCycles), 16'd3);

        // Branch in Decode while the multiply holds the pipe
        hz.StartMulE = 1'b1;
        step();
        hz.PCSrcD = 1'b1;
        #1;
        check("brm_stallf", 16'(hz.StallF), 16'd1);
        check("brm_stalld", 16'(hz.StallD), 16'd1);
        check("brm_flushd", 16'(hz.FlushD), 16'd0);
        step();
        check("brr_done",   16'(hz.MulDoneE), 16'd1);
        check("brr_flushd", 16'(hz.FlushD), 16'd1);
        check("brr_stallf", 16'(hz.StallF), 16'd1);
        step();
        quiet();
        #1;
        check("brr_cnt",    16'(hz.StallCycles), 16'd5);

        // Taken branch wins over a multiply start
        hz.StartMulE = 1'b1; hz.BranchTakenE = 1'b1;
        #1;
        check("bt_flushd", 16'(hz.FlushD), 16'd1);
        check("bt_flushe", 16'(hz.FlushE), 16'd1);
        check("bt_stalle", 16'(hz.StallE), 16'd0);
        check("bt_flushm", 16'(hz.FlushM), 16'd0);
        step();
        quiet();
        #1;
        check("bt_busy",   16'(hz.MulBusyE), 16'd0);
        check("bt_cnt",    16'(hz.StallCycles), 16'd5);

        // Reset in the second cycle of a multiply
        hz.StartMulE = 1'b1;
        step();
        check("rb_busy", 16'(hz.MulBusyE), 16'd1);
        reset = 1'b1;
        hz.StartMulE = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("rb_busy0",  16'(hz.MulBusyE), 16'd0);
        check("rb_stalle", 16'(hz.StallE), 16'd0);
        check("rb_cnt",    16'(hz.StallCycles), 16'd0);

        // Saturation: hold a load-use stall for 2^CNT_W+3 edges
        hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WA3E = 4'd5; hz.RA1D = 4'd5;
        for (int unsigned i = 1; i <= (1 << CNT_W) + 3; i++) begin
            step();
            if (i == (1 << CNT_W) - 2)
                check("sat_pre", 16'(hz.StallCycles), 16'((1 << CNT_W) - 2));
        end
        check("sat_hold", 16'(hz.StallCycles), 16'((1 << CNT_W) - 1));
        quiet();
        step();
        check("sat_rel",  16'(hz.StallCycles), 16'((1 << CNT_W) - 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
